tdp_ram_sc_parity: RTL and testbench

//  Parametrised single-clock true-dual-port RAM, successor to the fixed 36K mapping wrapper.

---
 rtl/tdp_ram_sc_parity_pkg.sv | 26 ++
 rtl/tdp_ram_sc_parity_if.sv | 27 ++
 rtl/tdp_ram_sc_parity_rd_pipe.sv | 60 ++++++
 rtl/tdp_ram_sc_parity.sv | 142 ++++++++++++++
 tb/tb_tdp_ram_sc_parity.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdp_ram_sc_parity_pkg.sv
// rtl/tdp_ram_sc_parity_pkg.sv - shared types and helpers for the parity-protected dual-port RAM
package tdp_ram_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_e;

  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_BW         = MAX_DATA_WIDTH / 8;

  function automatic bit data_width_legal(input int width);
    return (width >= 8) && (width <= MAX_DATA_WIDTH) && ((width % 8) == 0);
  endfunction

  // Even parity per byte lane; callers keep the low DATA_WIDTH/8 bits.
  function automatic logic [MAX_BW-1:0] byte_parity(input logic [MAX_DATA_WIDTH-1:0] data);
    logic [MAX_BW-1:0] par;
    for (int i = 0; i < MAX_BW; i++) begin
      par[i] = ^data[i*8 +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/tdp_ram_sc_parity_if.sv
// rtl/tdp_ram_sc_parity_if.sv - one RAM access port: request, write data and read response
interface tdp_ram_sc_parity_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  localparam int BW = DATA_WIDTH / 8;

  logic                  wen;
  logic                  ren;
  logic                  inj;
  logic [BW-1:0]         be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic [BW-1:0]         perr;

  modport master (
    output wen, ren, inj, be, addr, wdata,
    input  rdata, rvalid, perr
  );

  modport slave (
    input  wen, ren, inj, be, addr, wdata,
    output rdata, rvalid, perr
  );
endinterface

// File: rtl/tdp_ram_sc_parity_rd_pipe.sv
// rtl/tdp_ram_sc_parity_rd_pipe.sv - read latency pipeline with parity check for one port
module tdp_ram_rd_pipe
  import tdp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 rd_en,
  input  logic [DATA_WIDTH+DATA_WIDTH/8-1:0]   rd_word,
  output logic [DATA_WIDTH-1:0]                rdata,
  output logic                                 rvalid,
  output logic [DATA_WIDTH/8-1:0]              perr
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int WW = DATA_WIDTH + BW;

  logic          s_en;
  logic [WW-1:0] s_word;

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_en   <= 1'b0;
        s_word <= '0;
      end else begin
        s_en <= rd_en;
        if (rd_en) s_word <= rd_word;
      end
    end
  end else begin : g_no_out_reg
    assign s_en   = rd_en;
    assign s_word = rd_word;
  end

  logic [MAX_BW-1:0] par_full;
  logic [BW-1:0]     chk;
  logic              unused_par;

  assign par_full   = byte_parity(MAX_DATA_WIDTH'(s_word[DATA_WIDTH-1:0]));
  assign chk        = par_full[BW-1:0] ^ s_word[WW-1:DATA_WIDTH];
  assign unused_par = ^par_full;

  // Data and error flags hold between reads; rvalid marks the fresh ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      perr   <= '0;
    end else begin
      rvalid <= s_en;
      if (s_en) begin
        rdata <= s_word[DATA_WIDTH-1:0];
        perr  <= chk;
      end
    end
  end

endmodule

// File: rtl/tdp_ram_sc_parity.sv
// rtl/tdp_ram_sc_parity.sv - single-clock true-dual-port RAM with byte parity, collision flag and clear sweep
module tdp_ram_sc_parity
  import tdp_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int WRITE_FIRST    = 0,
  parameter int OUT_REG        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  tdp_ram_sc_parity_if.slave port_a,
  tdp_ram_sc_parity_if.slave port_b,
  output logic               init_done,
  output logic               collision
);
  localparam int  BW          = DATA_WIDTH / 8;
  localparam int  WW          = DATA_WIDTH + BW;
  localparam int  DEPTH       = 2 ** ADDR_WIDTH;
  localparam bit  WIDTH_LEGAL = data_width_legal(DATA_WIDTH);

  state_e                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  ready;

  // An illegal width never reaches READY, so the memory stays inert.
  assign ready     = (state == ST_READY) && WIDTH_LEGAL;
  assign init_done = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RST;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_RST: begin
          clr_cnt <= '0;
          state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
        end
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) state <= ST_READY;
        end
        default: state <= ST_READY;
      endcase
    end
  end

  logic [BW-1:0]     we_a, we_b;
  logic [MAX_BW-1:0] pfull_a, pfull_b;
  logic [BW-1:0]     wpar_a, wpar_b;
  logic              unused_par;
  logic              same_addr;

  assign we_a       = (ready && port_a.wen) ? port_a.be : '0;
  assign we_b       = (ready && port_b.wen) ? port_b.be : '0;
  assign pfull_a    = byte_parity(MAX_DATA_WIDTH'(port_a.wdata));
  assign pfull_b    = byte_parity(MAX_DATA_WIDTH'(port_b.wdata));
  assign wpar_a     = pfull_a[BW-1:0] ^ {BW{port_a.inj}};
  assign wpar_b     = pfull_b[BW-1:0] ^ {BW{port_b.inj}};
  assign unused_par = ^{pfull_a, pfull_b};
  assign same_addr  = (port_a.addr == port_b.addr);

  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] old_a, old_b, new_a, new_b;

  // new_x is the word at port x's address after this cycle's writes; A overrides B lane by lane.
  always_comb begin
    old_a = mem[port_a.addr];
    old_b = mem[port_b.addr];
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < BW; i++) begin
      if (we_b[i]) begin
        new_b[i*8 +: 8]      = port_b.wdata[i*8 +: 8];
        new_b[DATA_WIDTH+i]  = wpar_b[i];
        if (same_addr) begin
          new_a[i*8 +: 8]     = port_b.wdata[i*8 +: 8];
          new_a[DATA_WIDTH+i] = wpar_b[i];
        end
      end
      if (we_a[i]) begin
        new_a[i*8 +: 8]      = port_a.wdata[i*8 +: 8];
        new_a[DATA_WIDTH+i]  = wpar_a[i];
        if (same_addr) begin
          new_b[i*8 +: 8]     = port_a.wdata[i*8 +: 8];
          new_b[DATA_WIDTH+i] = wpar_a[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (|we_b) mem[port_b.addr] <= new_b;
      if (|we_a) mem[port_a.addr] <= new_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision <= 1'b0;
    else        collision <= same_addr && (|(we_a & we_b));
  end

  logic          rd_en_a, rd_en_b;
  logic [WW-1:0] rd_word_a, rd_word_b;

  assign rd_en_a   = ready && port_a.ren;
  assign rd_en_b   = ready && port_b.ren;
  assign rd_word_a = (WRITE_FIRST != 0) ? new_a : old_a;
  assign rd_word_b = (WRITE_FIRST != 0) ? new_b : old_b;

  tdp_ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_rd_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_en_a),
    .rd_word (rd_word_a),
    .rdata   (port_a.rdata),
    .rvalid  (port_a.rvalid),
    .perr    (port_a.perr)
  );

  tdp_ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_rd_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_en_b),
    .rd_word (rd_word_b),
    .rdata   (port_b.rdata),
    .rvalid  (port_b.rvalid),
    .perr    (port_b.perr)
  );

endmodule

// File: tb/tb_tdp_ram_sc_parity.sv
// tb/tb_tdp_ram_sc_parity.sv - vector bench for two RAM configurations (read-first/OUT_REG=1, write-first/OUT_REG=0)
module tb_tdp_ram_sc_parity;

  logic clk;
  logic rst_n;
  logic init_done0, init_done1, coll0, coll1;
  int   total;
  int   passed;

  tdp_ram_sc_parity_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) a0 ();
  tdp_ram_sc_parity_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b0 ();
  tdp_ram_sc_parity_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) a1 ();
  tdp_ram_sc_parity_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b1 ();

  tdp_ram_sc_parity #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .WRITE_FIRST(0), .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .port_a(a0), .port_b(b0), .init_done(init_done0), .collision(coll0)
  );

  tdp_ram_sc_parity #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .WRITE_FIRST(1), .OUT_REG(0), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .port_a(a1), .port_b(b1), .init_done(init_done1), .collision(coll1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          wr;
    bit          port;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          inj;
    logic [31:0] exp_data;
    logic [3:0]  exp_perr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t wr_v(bit p, logic [3:0] ad, logic [31:0] d, logic [3:0] be, bit inj);
    vec_t v;
    v = '{wr: 1'b1, port: p, addr: ad, data: d, be: be, inj: inj, exp_data: 32'h0, exp_perr: 4'h0};
    return v;
  endfunction

  function automatic vec_t rd_v(bit p, logic [3:0] ad, logic [31:0] ed, logic [3:0] ep);
    vec_t v;
    v = '{wr: 1'b0, port: p, addr: ad, data: 32'h0, be: 4'h0, inj: 1'b0, exp_data: ed, exp_perr: ep};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    a0.wen = 0; a0.ren = 0; a0.inj = 0; a0.be = '0; a0.addr = '0; a0.wdata = '0;
    b0.wen = 0; b0.ren = 0; b0.inj = 0; b0.be = '0; b0.addr = '0; b0.wdata = '0;
    a1.wen = 0; a1.ren = 0; a1.inj = 0; a1.be = '0; a1.addr = '0; a1.wdata = '0;
    b1.wen = 0; b1.ren = 0; b1.inj = 0; b1.be = '0; b1.addr = '0; b1.wdata = '0;
  endtask

  task automatic set_wr(input bit p, input logic [3:0] ad, input logic [31:0] d,
                        input logic [3:0] be, input bit inj);
    if (!p) begin
      a0.wen = 1; a0.addr = ad; a0.wdata = d; a0.be = be; a0.inj = inj;
      a1.wen = 1; a1.addr = ad; a1.wdata = d; a1.be = be; a1.inj = inj;
    end else begin
      b0.wen = 1; b0.addr = ad; b0.wdata = d; b0.be = be; b0.inj = inj;
      b1.wen = 1; b1.addr = ad; b1.wdata = d; b1.be = be; b1.inj = inj;
    end
  endtask

  task automatic set_rd(input bit p, input logic [3:0] ad);
    if (!p) begin
      a0.ren = 1; a0.addr = ad; a1.ren = 1; a1.addr = ad;
    end else begin
      b0.ren = 1; b0.addr = ad; b1.ren = 1; b1.addr = ad;
    end
  endtask

  task automatic do_read(input bit p, input logic [3:0] ad,
                         output logic [31:0] d0, output logic [3:0] p0, output int l0,
                         output logic [31:0] d1, output logic [3:0] p1, output int l1);
    set_rd(p, ad);
    l0 = 0; l1 = 0; d0 = 'x; d1 = 'x; p0 = 'x; p1 = 'x;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) drive_idle();
      if (l0 == 0 && (p ? b0.rvalid : a0.rvalid)) begin
        l0 = k; d0 = p ? b0.rdata : a0.rdata; p0 = p ? b0.perr : a0.perr;
      end
      if (l1 == 0 && (p ? b1.rvalid : a1.rvalid)) begin
        l1 = k; d1 = p ? b1.rdata : a1.rdata; p1 = p ? b1.perr : a1.perr;
      end
    end
  endtask

  task automatic read_check(input string tag, input bit p, input logic [3:0] ad,
                            input logic [31:0] e0, input logic [31:0] e1, input logic [3:0] ep);
    logic [31:0] d0, d1;
    logic [3:0]  p0, p1;
    int          l0, l1;
    do_read(p, ad, d0, p0, l0, d1, p1, l1);
    check({tag, "_data0"}, d0, e0);
    check({tag, "_perr0"}, 32'(p0), 32'(ep));
    check({tag, "_lat0"}, 32'(l0), 32'd2);
    check({tag, "_data1"}, d1, e1);
    check({tag, "_perr1"}, 32'(p1), 32'(ep));
    check({tag, "_lat1"}, 32'(l1), 32'd1);
  endtask

  task automatic count_sweep(input string tag, input bit poll_read);
    int n;
    bit seen_rv;
    n = 0;
    seen_rv = 0;
    if (poll_read) set_rd(0, 4'h3);
    while (!init_done0 && n < 100) begin
      step();
      n++;
      if (a0.rvalid || a1.rvalid) seen_rv = 1;
    end
    drive_idle();
    check({tag, "_sweep_cycles"}, 32'(n), 32'd16);
    check({tag, "_init_done1"}, 32'(init_done1), 32'd1);
    if (poll_read) check({tag, "_dropped_reads"}, 32'(seen_rv), 32'd0);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_n = 0;
    drive_idle();

    for (int i = 0; i < 16; i++) vecs.push_back(rd_v(i[0], 4'(i), 32'h0, 4'h0));
    vecs.push_back(wr_v(0, 4'h3, 32'hDEADBEEF, 4'hF, 0));
    vecs.push_back(rd_v(1, 4'h3, 32'hDEADBEEF, 4'h0));
    vecs.push_back(wr_v(0, 4'h9, 32'hCAFEF00D, 4'h5, 0));
    vecs.push_back(rd_v(0, 4'h9, 32'h00FE000D, 4'h0));
    vecs.push_back(wr_v(1, 4'h9, 32'h12345678, 4'h8, 0));
    vecs.push_back(rd_v(1, 4'h9, 32'h12FE000D, 4'h0));
    vecs.push_back(wr_v(0, 4'hA, 32'hFFFFFFFF, 4'h0, 0));
    vecs.push_back(rd_v(0, 4'hA, 32'h00000000, 4'h0));
    vecs.push_back(wr_v(0, 4'hB, 32'h01020304, 4'hF, 1));
    vecs.push_back(rd_v(1, 4'hB, 32'h01020304, 4'hF));
    vecs.push_back(wr_v(0, 4'hB, 32'h01020304, 4'hF, 0));
    vecs.push_back(rd_v(0, 4'hB, 32'h01020304, 4'h0));
    vecs.push_back(wr_v(0, 4'hC, 32'h000000FF, 4'h1, 1));
    vecs.push_back(rd_v(0, 4'hC, 32'h000000FF, 4'h1));

    step(); step(); step();
    check("rst_rdata", a0.rdata, 32'h0);
    check("rst_rvalid", {30'h0, a0.rvalid, b0.rvalid}, 32'h0);
    check("rst_perr", {24'h0, a0.perr, b0.perr}, 32'h0);
    check("rst_collision", 32'(coll0), 32'h0);
    check("rst_init_done", {30'h0, init_done0, init_done1}, 32'h0);

    rst_n = 1;
    step();
    check("rel_init_done_low", 32'(init_done0), 32'h0);
    count_sweep("first", 1'b0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        set_wr(vecs[i].port, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].inj);
        step();
        drive_idle();
      end else begin
        read_check($sformatf("v%0d", i), vecs[i].port, vecs[i].addr,
                   vecs[i].exp_data, vecs[i].exp_data, vecs[i].exp_perr);
      end
    end

    // Same-cycle write on B and read on A of word 7 (still zero from the sweep).
    set_wr(1, 4'h7, 32'hFFFFFFFF, 4'hF, 0);
    read_check("rdw7", 0, 4'h7, 32'h00000000, 32'hFFFFFFFF, 4'h0);
    read_check("rd7", 0, 4'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0);

    // Both ports write word 5 with overlapping byte enables.
    set_wr(0, 4'h5, 32'h77000000, 4'h8, 0);
    step();
    drive_idle();
    set_wr(0, 4'h5, 32'h11223344, 4'h3, 0);
    set_wr(1, 4'h5, 32'hAABBCCDD, 4'h6, 0);
    check("coll_before", 32'(coll0), 32'h0);
    step();
    drive_idle();
    check("coll_pulse", {30'h0, coll0, coll1}, 32'h3);
    step();
    check("coll_end", {30'h0, coll0, coll1}, 32'h0);
    read_check("coll5", 1, 4'h5, 32'h77BB3344, 32'h77BB3344, 4'h0);

    set_wr(0, 4'h6, 32'h000000AA, 4'h1, 0);
    set_wr(1, 4'h6, 32'hBB000000, 4'h8, 0);
    step();
    drive_idle();
    check("nocoll", {30'h0, coll0, coll1}, 32'h0);
    read_check("merge6", 0, 4'h6, 32'hBB0000AA, 32'hBB0000AA, 4'h0);

    // Back-to-back reads on A of dut0, then hold.
    set_rd(0, 4'h3);
    step();
    check("b2b_rv_0", 32'(a0.rvalid), 32'h0);
    set_rd(0, 4'h9);
    step();
    drive_idle();
    check("b2b_rv_1", 32'(a0.rvalid), 32'h1);
    check("b2b_d_1", a0.rdata, 32'hDEADBEEF);
    step();
    check("b2b_rv_2", 32'(a0.rvalid), 32'h1);
    check("b2b_d_2", a0.rdata, 32'h12FE000D);
    step();
    check("hold_rv", {30'h0, a0.rvalid, a1.rvalid}, 32'h0);
    check("hold_d0", a0.rdata, 32'h12FE000D);
    check("hold_d1", a1.rdata, 32'h12FE000D);

    // Reset during a read: valid output of dut1 must vanish at once.
    set_rd(0, 4'h3);
    step();
    drive_idle();
    check("inflight_rv1", 32'(a1.rvalid), 32'h1);
    rst_n = 0;
    #1;
    check("arst_rv", {30'h0, a0.rvalid, a1.rvalid}, 32'h0);
    check("arst_d0", a0.rdata, 32'h0);
    check("arst_d1", a1.rdata, 32'h0);
    check("arst_init", {30'h0, init_done0, init_done1}, 32'h0);
    step();
    step();
    check("arst_inflight_lost", 32'(a0.rvalid), 32'h0);

    rst_n = 1;
    step();
    for (int i = 0; i < 5; i++) step();
    check("midsweep_init", 32'(init_done0), 32'h0);
    rst_n = 0;
    #1;
    check("midsweep_rst_init", {30'h0, init_done0, init_done1}, 32'h0);
    check("midsweep_rst_out", {29'h0, a0.rvalid, b0.rvalid, coll0}, 32'h0);
    step();
    rst_n = 1;
    step();
    count_sweep("second", 1'b1);
    read_check("recleared3", 0, 4'h3, 32'h0, 32'h0, 4'h0);
    read_check("recleared9", 1, 4'h9, 32'h0, 32'h0, 4'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
